multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
FSM that sequences the shared multicycle RV32I datapath: PC, instruction register, unified memory, register file, immediate generator and a single ALU.
- Decodes the opcode latched in the IR.
- Steps each instruction through fetch / decode / execute / memory / writeback, one state per cycle.
- Stalls on a memory ready handshake.
- Drives every datapath mux select and write enable.

Parameters:
OPCODE_W, 7, opcode field width
ST_W, 4, state register width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  7  IR[6:0], valid from DECODE onward
mem_ready  input  1  memory completes current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU branch-taken flag set
i_or_d  output  1  memory address: 0=PC, 1=ALU_out
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  latch fetched word into IR
reg_write  output  1  register-file write enable
alu_src_a  output  2  0=PC, 1=rs1, 2=old_PC, 3=zero
alu_src_b  output  2  0=rs2, 1=const 4, 2=imm
alu_op  output  2  0=add, 1=branch compare, 2=funct-decoded
pc_src  output  2  0=ALU result, 1=ALU_out, 2=ALU result & ~1
mem_to_reg  output  2  0=ALU_out, 1=MDR, 2=PC(+4)
illegal_instr  output  1  one-cycle pulse on unsupported opcode
state_dbg  output  ST_W  current state

Behaviour:
- Reset (rst_n low, async): state=FETCH; all enables 0; all selects 0.
- Enables/selects are Moore decodes of state, except the FETCH and MEM_RD/MEM_WR completion strobes, which are qualified by mem_ready.
- Any state not listed below: every enable 0, selects don't-care.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0.
  - Hold while mem_ready=0.
  - On mem_ready=1 in the same cycle: ir_write=1, pc_write=1 (PC+4); next state DECODE.
- DECODE: alu_src_a=2, alu_src_b=2, alu_op=0 (old_PC+imm into ALU_out for branch/JAL).
  - opcode 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 / 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - any other opcode -> FETCH with illegal_instr=1 for one cycle; no register or memory write.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=2 -> ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op=2 -> ALU_WB.
- LUI: alu_src_a=3, alu_src_b=2, alu_op=0 -> ALU_WB.
- AUIPC: alu_src_a=2, alu_src_b=2, alu_op=0 -> ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0. Next state MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready, then -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1 -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready, then -> FETCH. mem_write stays asserted throughout the wait.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_src=1 -> FETCH.
- JAL: pc_write=1, pc_src=1, reg_write=1, mem_to_reg=2 -> FETCH.
- JALR: alu_src_a=1, alu_src_b=2, alu_op=0, pc_write=1, pc_src=2, reg_write=1, mem_to_reg=2 -> FETCH.
- Latency in cycles, with mem_ready=1 on first request:
  - R / I / LUI / AUIPC: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL / JALR: 3
  - Each mem_ready=0 cycle adds one cycle.
- Boundaries:
  - mem_read and mem_write are never both 1.
  - Reset mid-wait aborts the access immediately; no write completes.
  - An unreachable state encoding recovers to FETCH on the next clock.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - opcode constants (same values as the immediate generator);
  - state encodings;
  - alu_src_a/b, alu_op, pc_src, mem_to_reg select encodings.
- One natural sub-module, ctrl_output_decoder: combinational state(+mem_ready) -> control vector.
- The FSM next-state logic stays in the top.

Test Plan:
- Reset: rst_n=0 asserted asynchronously mid-MEM_WR -> outputs 0 immediately, state_dbg=FETCH.
- ADDI (0010011), mem_ready=1 -> states FETCH, DECODE, EXEC_I, ALU_WB; reg_write=1 in cycle 4 only; pc_write=1 in cycle 1 only.
- LW (0000011), mem_ready low 2 cycles in MEM_RD -> MEM_RD held 3 cycles, then MEM_WB with mem_to_reg=1; total 7 cycles.
- SW (0100011) -> MEM_WR asserts mem_write with i_or_d=1; reg_write never asserted.
- BEQ (1100011) -> BRANCH asserts pc_write_cond=1, pc_src=1, alu_op=1; back in FETCH at cycle 4.
- JALR (1100111) -> pc_src=2, mem_to_reg=2, reg_write=1.
- Opcode 1111111 -> illegal_instr pulses 1 cycle in DECODE, then FETCH; no write enables.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit:
// opcodes, FSM states, datapath mux selects and the control bundle.
package riscv_ctrl_pkg;

    localparam int OPCODE_W = 7;
    localparam int ST_W     = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JAL      = 4'd9,
        S_JALR     = 4'd10,
        S_LUI      = 4'd11,
        S_AUIPC    = 4'd12,
        S_ALU_WB   = 4'd13
    } state_e;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_RS1   = 2'd1;
    localparam logic [1:0] SRCA_OLDPC = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_BR    = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JALR   = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic [1:0] mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_ctrl_output_decoder.sv
// Combinational state (+mem_ready) to datapath control vector.
// Only fetch and memory-access completion strobes depend on mem_ready.
module ctrl_output_decoder
    import riscv_ctrl_pkg::*;
(
    input  state_e i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.i_or_d    = 1'b0;
                o_ctrl.alu_src_a = SRCA_PC;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.pc_src    = PC_ALU;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_a = SRCA_OLDPC;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            S_EXEC_R: begin
                o_ctrl.alu_src_a = SRCA_RS1;
                o_ctrl.alu_src_b = SRCB_RS2;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            S_EXEC_I: begin
                o_ctrl.alu_src_a = SRCA_RS1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            S_LUI: begin
                o_ctrl.alu_src_a = SRCA_ZERO;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            S_AUIPC: begin
                o_ctrl.alu_src_a = SRCA_OLDPC;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            S_ALU_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = WB_ALUOUT;
            end
            S_MEM_ADDR: begin
                o_ctrl.alu_src_a = SRCA_RS1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = WB_MDR;
            end
            S_MEM_WR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = SRCA_RS1;
                o_ctrl.alu_src_b     = SRCB_RS2;
                o_ctrl.alu_op        = ALU_BR;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_src        = PC_ALUOUT;
            end
            S_JAL: begin
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.pc_src     = PC_ALUOUT;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = WB_PC;
            end
            S_JALR: begin
                o_ctrl.alu_src_a  = SRCA_RS1;
                o_ctrl.alu_src_b  = SRCB_IMM;
                o_ctrl.alu_op     = ALU_ADD;
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.pc_src     = PC_JALR;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = WB_PC;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I sequencer: FSM next-state logic plus output decode.
// Outputs are forced to zero while reset is held.
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 7,
    parameter int ST_W     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_src,
    output logic [1:0]          mem_to_reg,
    output logic                illegal_instr,
    output logic [ST_W-1:0]     state_dbg
);

    state_e     r_state;
    state_e     w_next;
    ctrl_t      w_ctrl;
    ctrl_t      w_ctrl_q;
    logic [6:0] w_op;
    logic       w_illegal;

    assign w_op = w_op_ext(opcode);

    function automatic logic [6:0] w_op_ext(input logic [OPCODE_W-1:0] op);
        logic [6:0] v;
        v = '0;
        for (int i = 0; i < 7 && i < OPCODE_W; i++) v[i] = op[i];
        return v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = S_FETCH;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (1'b1)
                    (w_op == OP_R):      w_next = S_EXEC_R;
                    (w_op == OP_IMM):    w_next = S_EXEC_I;
                    (w_op == OP_LOAD),
                    (w_op == OP_STORE):  w_next = S_MEM_ADDR;
                    (w_op == OP_BRANCH): w_next = S_BRANCH;
                    (w_op == OP_JAL):    w_next = S_JAL;
                    (w_op == OP_JALR):   w_next = S_JALR;
                    (w_op == OP_LUI):    w_next = S_LUI;
                    (w_op == OP_AUIPC):  w_next = S_AUIPC;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I,
            S_LUI, S_AUIPC: w_next = S_ALU_WB;
            S_MEM_ADDR: w_next = (w_op == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
            default:    w_next = S_FETCH;
        endcase
    end

    ctrl_output_decoder u_dec (
        .i_state     (r_state),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    // Gate with rst_n so an access in flight is dropped the instant reset asserts.
    assign w_ctrl_q      = rst_n ? w_ctrl : '0;
    assign pc_write      = w_ctrl_q.pc_write;
    assign pc_write_cond = w_ctrl_q.pc_write_cond;
    assign i_or_d        = w_ctrl_q.i_or_d;
    assign mem_read      = w_ctrl_q.mem_read;
    assign mem_write     = w_ctrl_q.mem_write;
    assign ir_write      = w_ctrl_q.ir_write;
    assign reg_write     = w_ctrl_q.reg_write;
    assign alu_src_a     = w_ctrl_q.alu_src_a;
    assign alu_src_b     = w_ctrl_q.alu_src_b;
    assign alu_op        = w_ctrl_q.alu_op;
    assign pc_src        = w_ctrl_q.pc_src;
    assign mem_to_reg    = w_ctrl_q.mem_to_reg;
    assign illegal_instr = rst_n & w_illegal;
    assign state_dbg     = ST_W'(r_state);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-instruction state
// sequences, control strobes, stalls, illegal opcode and async reset.
module tb_multicycle_control_unit;

    localparam logic [3:0] F   = 4'd0;
    localparam logic [3:0] D   = 4'd1;
    localparam logic [3:0] ER  = 4'd2;
    localparam logic [3:0] EI  = 4'd3;
    localparam logic [3:0] MA  = 4'd4;
    localparam logic [3:0] MR  = 4'd5;
    localparam logic [3:0] MWB = 4'd6;
    localparam logic [3:0] MW  = 4'd7;
    localparam logic [3:0] BR  = 4'd8;
    localparam logic [3:0] JR  = 4'd10;
    localparam logic [3:0] LU  = 4'd11;
    localparam logic [3:0] AWB = 4'd13;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic       ir_write, reg_write, illegal_instr;
    logic [1:0] alu_src_a, alu_src_b, alu_op, pc_src, mem_to_reg;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_src        (pc_src),
        .mem_to_reg    (mem_to_reg),
        .illegal_instr (illegal_instr),
        .state_dbg     (state_dbg)
    );

    wire [18:0] all_out = {pc_write, pc_write_cond, i_or_d, mem_read,
                           mem_write, ir_write, reg_write, alu_src_a,
                           alu_src_b, alu_op, pc_src, mem_to_reg,
                           illegal_instr};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b0; opcode = 7'd0;
        #2;
        checks++;
        if (all_out !== 19'd0) begin
            errors++;
            $display("FAIL reset_outs got=%h exp=0", all_out);
        end
        checks++;
        if (state_dbg !== F) begin
            errors++;
            $display("FAIL reset_state got=%0d exp=%0d", state_dbg, F);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_addi();
        logic [3:0] es[4] = '{F, D, EI, AWB};
        opcode = 7'b0010011;
        for (int c = 0; c < 4; c++) begin
            mem_ready = 1'b1;
            #1;
            checks++;
            if (state_dbg !== es[c]) begin
                errors++;
                $display("FAIL addi_state c%0d got=%0d exp=%0d", c, state_dbg, es[c]);
            end
            checks++;
            if (reg_write !== (c == 3)) begin
                errors++;
                $display("FAIL addi_regw c%0d got=%b exp=%b", c, reg_write, c == 3);
            end
            checks++;
            if (pc_write !== (c == 0)) begin
                errors++;
                $display("FAIL addi_pcw c%0d got=%b exp=%b", c, pc_write, c == 0);
            end
            if (c == 2) begin
                checks++;
                if ({alu_src_a, alu_src_b, alu_op} !== {2'd1, 2'd2, 2'd2}) begin
                    errors++;
                    $display("FAIL addi_exec got=%b exp=011010", {alu_src_a, alu_src_b, alu_op});
                end
            end
            tick();
        end
        checks++;
        if (state_dbg !== F) begin
            errors++;
            $display("FAIL addi_done got=%0d exp=%0d", state_dbg, F);
        end
    endtask

    task automatic test_load_stall();
        logic [3:0] es[7] = '{F, D, MA, MR, MR, MR, MWB};
        logic       rd[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = 7'b0000011;
        for (int c = 0; c < 7; c++) begin
            mem_ready = rd[c];
            #1;
            checks++;
            if (state_dbg !== es[c]) begin
                errors++;
                $display("FAIL lw_state c%0d got=%0d exp=%0d", c, state_dbg, es[c]);
            end
            if (es[c] == MR) begin
                checks++;
                if ({mem_read, i_or_d, mem_write} !== 3'b110) begin
                    errors++;
                    $display("FAIL lw_memrd c%0d got=%b exp=110", c, {mem_read, i_or_d, mem_write});
                end
            end
            if (c == 6) begin
                checks++;
                if ({reg_write, mem_to_reg} !== 3'b101) begin
                    errors++;
                    $display("FAIL lw_wb got=%b exp=101", {reg_write, mem_to_reg});
                end
            end
            tick();
        end
        checks++;
        if (state_dbg !== F) begin
            errors++;
            $display("FAIL lw_done got=%0d exp=%0d", state_dbg, F);
        end
    endtask

    task automatic test_store();
        logic [3:0] es[4] = '{F, D, MA, MW};
        int         regw = 0;
        opcode = 7'b0100011;
        for (int c = 0; c < 4; c++) begin
            mem_ready = 1'b1;
            #1;
            if (reg_write) regw++;
            checks++;
            if (state_dbg !== es[c]) begin
                errors++;
                $display("FAIL sw_state c%0d got=%0d exp=%0d", c, state_dbg, es[c]);
            end
            if (c == 3) begin
                checks++;
                if ({mem_write, i_or_d, mem_read} !== 3'b110) begin
                    errors++;
                    $display("FAIL sw_memwr got=%b exp=110", {mem_write, i_or_d, mem_read});
                end
            end
            tick();
        end
        checks++;
        if (regw !== 0 || state_dbg !== F) begin
            errors++;
            $display("FAIL sw_done regw=%0d state=%0d exp regw=0 state=0", regw, state_dbg);
        end
    endtask

    task automatic test_reset_mid_write();
        opcode = 7'b0100011;
        mem_ready = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if ({state_dbg, mem_write, i_or_d} !== {MW, 2'b11}) begin
                errors++;
                $display("FAIL wr_wait c%0d got=%0d/%b exp=%0d/11", c, state_dbg, {mem_write, i_or_d}, MW);
            end
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_out !== 19'd0) begin
            errors++;
            $display("FAIL rst_mid_outs got=%h exp=0", all_out);
        end
        checks++;
        if (state_dbg !== F) begin
            errors++;
            $display("FAIL rst_mid_state got=%0d exp=%0d", state_dbg, F);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_branch();
        logic [3:0] es[3] = '{F, D, BR};
        opcode = 7'b1100011;
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (state_dbg !== es[c]) begin
                errors++;
                $display("FAIL beq_state c%0d got=%0d exp=%0d", c, state_dbg, es[c]);
            end
            if (c == 2) begin
                checks++;
                if ({pc_write_cond, pc_src, alu_op, pc_write} !== 6'b101010) begin
                    errors++;
                    $display("FAIL beq_ctrl got=%b exp=101010", {pc_write_cond, pc_src, alu_op, pc_write});
                end
            end
            tick();
        end
        checks++;
        if (state_dbg !== F) begin
            errors++;
            $display("FAIL beq_done got=%0d exp=%0d", state_dbg, F);
        end
    endtask

    task automatic test_jalr();
        opcode = 7'b1100111;
        mem_ready = 1'b1;
        tick(); tick();
        #1;
        checks++;
        if (state_dbg !== JR) begin
            errors++;
            $display("FAIL jalr_state got=%0d exp=%0d", state_dbg, JR);
        end
        checks++;
        if ({pc_src, mem_to_reg, reg_write, pc_write} !== 6'b101011) begin
            errors++;
            $display("FAIL jalr_ctrl got=%b exp=101011", {pc_src, mem_to_reg, reg_write, pc_write});
        end
        tick();
        checks++;
        if (state_dbg !== F) begin
            errors++;
            $display("FAIL jalr_done got=%0d exp=%0d", state_dbg, F);
        end
    endtask

    task automatic test_illegal();
        opcode = 7'b1111111;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (illegal_instr !== 1'b0) begin
            errors++;
            $display("FAIL ill_fetch got=%b exp=0", illegal_instr);
        end
        tick();
        #1;
        checks++;
        if ({state_dbg, illegal_instr} !== {D, 1'b1}) begin
            errors++;
            $display("FAIL ill_decode got=%0d/%b exp=%0d/1", state_dbg, illegal_instr, D);
        end
        checks++;
        if ({pc_write, pc_write_cond, mem_write, reg_write, ir_write} !== 5'd0) begin
            errors++;
            $display("FAIL ill_enables got=%b exp=00000",
                     {pc_write, pc_write_cond, mem_write, reg_write, ir_write});
        end
        tick();
        checks++;
        if ({state_dbg, illegal_instr} !== {F, 1'b0}) begin
            errors++;
            $display("FAIL ill_after got=%0d/%b exp=%0d/0", state_dbg, illegal_instr, F);
        end
    endtask

    task automatic test_back_to_back();
        opcode = 7'b0110011;
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({mem_read, ir_write, pc_write} !== 3'b100) begin
            errors++;
            $display("FAIL fetch_stall got=%b exp=100", {mem_read, ir_write, pc_write});
        end
        tick();
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({state_dbg, ir_write, alu_src_b} !== {F, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL fetch_go got=%0d/%b/%0d exp=0/1/1", state_dbg, ir_write, alu_src_b);
        end
        tick(); tick();
        #1;
        checks++;
        if ({state_dbg, alu_src_a, alu_src_b, alu_op} !== {ER, 6'b010010}) begin
            errors++;
            $display("FAIL exec_r got=%0d/%b exp=%0d/010010", state_dbg, {alu_src_a, alu_src_b, alu_op}, ER);
        end
        tick(); tick();
        opcode = 7'b0110111;
        tick(); tick();
        #1;
        checks++;
        if ({state_dbg, alu_src_a, alu_src_b, alu_op} !== {LU, 6'b111000}) begin
            errors++;
            $display("FAIL lui got=%0d/%b exp=%0d/111000", state_dbg, {alu_src_a, alu_src_b, alu_op}, LU);
        end
        tick();
        #1;
        checks++;
        if ({state_dbg, reg_write} !== {AWB, 1'b1}) begin
            errors++;
            $display("FAIL lui_wb got=%0d/%b exp=%0d/1", state_dbg, reg_write, AWB);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_stall();
        test_store();
        test_reset_mid_write();
        test_branch();
        test_jalr();
        test_illegal();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
